wb_repeat_regbank: RTL and testbench

Wishbone classic-pipelined slave that exposes a bank of `N_CH` identical channels, each with one read/write control register and one read-only status register. It is the parametrised successor of the fixed two-entry repeated I/O group. It adds configurable channel count, byte-select writes, read-back of control registers, per-channel write strobes and optional error response on unmapped addresses. It sits directly on the CSR Wishbone bus beside other generated register blocks.

---
 rtl/wb_regbank_pkg.sv | 37 +++
 rtl/wb_regbank_chan.sv | 35 +++
 rtl/wb_repeat_regbank.sv | 137 +++++++++++++
 tb/tb_wb_repeat_regbank.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_regbank_pkg.sv
// rtl/wb_regbank_pkg.sv - shared widths, address-width helper and word decode for the register bank
package wb_regbank_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    typedef enum logic [1:0] {
        REG_CTRL,
        REG_STAT,
        REG_NONE
    } t_reg_kind;

    typedef struct packed {
        t_reg_kind  kind;
        logic [5:0] chan;
    } t_decode;

    // Byte-address width of the bank: two words per channel plus the byte offset.
    function automatic int unsigned regbank_adr_w(input int unsigned n_ch);
        return $clog2(2 * n_ch) + 2;
    endfunction

    // Even word 2c is ctrl of channel c, odd word 2c+1 is its stat.
    function automatic t_decode regbank_decode(input logic [31:0] word, input int unsigned n_ch);
        t_decode d;
        d.chan = word[6:1];
        if (word >= 2 * n_ch) begin
            d.kind = REG_NONE;
        end else if (word[0]) begin
            d.kind = REG_STAT;
        end else begin
            d.kind = REG_CTRL;
        end
        return d;
    endfunction

endpackage

// File: rtl/wb_regbank_chan.sv
// rtl/wb_regbank_chan.sv - one channel control register with byte-enable write and write strobe
// Ports: clk_i, rst_n_i (async active-low); wr_en_i, sel_i, dat_i write request;
//        ctrl_o register value; wr_stb_o one-cycle pulse coincident with the new value.
module wb_regbank_chan
    import wb_regbank_pkg::*;
#(
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [DATA_W-1:0] dat_i,
    output logic [DATA_W-1:0] ctrl_o,
    output logic              wr_stb_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_o   <= RST_VAL;
            wr_stb_o <= 1'b0;
        end else begin
            // The strobe fires even for sel=0 so software sees every write attempt.
            wr_stb_o <= wr_en_i;
            if (wr_en_i) begin
                for (int b = 0; b < SEL_W; b++) begin
                    if (sel_i[b]) begin
                        ctrl_o[8*b +: 8] <= dat_i[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/wb_repeat_regbank.sv
// rtl/wb_repeat_regbank.sv - Wishbone pipelined slave exposing N_CH ctrl (RW) / stat (RO) register pairs
// Ports: clk_i, rst_n_i (async active-low); wb_* Wishbone slave; ctrl_o packed control registers;
//        stat_i packed status inputs; wr_stb_o per-channel write pulses.
// Build option: WB_REGBANK_ERR_EN makes unmapped accesses and stat writes complete with err.
module wb_repeat_regbank
    import wb_regbank_pkg::*;
#(
    parameter int unsigned       N_CH    = 4,
    parameter logic [DATA_W-1:0] RST_VAL = 32'h0000_0000,
    localparam int unsigned      ADR_W   = regbank_adr_w(N_CH)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [ADR_W-1:2]       wb_adr_i,
    input  logic [SEL_W-1:0]       wb_sel_i,
    input  logic [DATA_W-1:0]      wb_dat_i,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   wb_rty_o,
    output logic                   wb_stall_o,
    output logic [DATA_W-1:0]      wb_dat_o,
    output logic [N_CH*DATA_W-1:0] ctrl_o,
    input  logic [N_CH*DATA_W-1:0] stat_i,
    output logic [N_CH-1:0]        wr_stb_o
);

    localparam int unsigned IDX_W = ADR_W - 2;

    logic              wb_en;
    logic              rd_acc, wr_acc;
    logic              rd_busy, wr_busy;
    logic              rd_ack, rd_err, wr_ack, wr_err;
    logic              rd_bad, wr_bad;
    t_decode           req_dec, d0_dec;
    logic [DATA_W-1:0] rd_data;
    logic              d0_vld;
    logic [IDX_W-1:0]  d0_adr;
    logic [DATA_W-1:0] d0_dat;
    logic [SEL_W-1:0]  d0_sel;

    assign wb_en   = wb_cyc_i & wb_stb_i;
    // Reads and writes are tracked independently; a held request is ignored
    // while its own kind is still awaiting the response.
    assign rd_acc  = wb_en & ~wb_we_i & ~rd_busy;
    assign wr_acc  = wb_en & wb_we_i & ~wr_busy;
    assign req_dec = regbank_decode(32'(wb_adr_i), N_CH);
    assign d0_dec  = regbank_decode(32'(d0_adr), N_CH);

`ifdef WB_REGBANK_ERR_EN
    assign rd_bad = (req_dec.kind == REG_NONE);
    assign wr_bad = (req_dec.kind != REG_CTRL);
`else
    assign rd_bad = 1'b0;
    assign wr_bad = 1'b0;
`endif

    assign wb_ack_o   = rd_ack | wr_ack;
    assign wb_err_o   = rd_err | wr_err;
    assign wb_rty_o   = 1'b0;
    assign wb_stall_o = wb_en & ~(wb_ack_o | wb_err_o);

    // Constant-index loop keeps the mux free of variable part-selects.
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (req_dec.chan == 6'(c)) begin
                if (req_dec.kind == REG_CTRL) begin
                    rd_data = ctrl_o[DATA_W*c +: DATA_W];
                end else if (req_dec.kind == REG_STAT) begin
                    rd_data = stat_i[DATA_W*c +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ack   <= 1'b0;
            rd_err   <= 1'b0;
            wr_ack   <= 1'b0;
            wr_err   <= 1'b0;
            rd_busy  <= 1'b0;
            wr_busy  <= 1'b0;
            wb_dat_o <= '0;
            d0_vld   <= 1'b0;
            d0_adr   <= '0;
            d0_dat   <= '0;
            d0_sel   <= '0;
        end else begin
            rd_ack <= rd_acc & ~rd_bad;
            rd_err <= rd_acc & rd_bad;
            wr_ack <= wr_acc & ~wr_bad;
            wr_err <= wr_acc & wr_bad;

            // The flag clears on the response even if cyc has already dropped.
            if (rd_acc) begin
                rd_busy <= 1'b1;
            end else if (rd_ack | rd_err) begin
                rd_busy <= 1'b0;
            end
            if (wr_acc) begin
                wr_busy <= 1'b1;
            end else if (wr_ack | wr_err) begin
                wr_busy <= 1'b0;
            end

            if (rd_acc) begin
                wb_dat_o <= rd_data;
            end

            d0_vld <= wr_acc;
            if (wr_acc) begin
                d0_adr <= wb_adr_i;
                d0_dat <= wb_dat_i;
                d0_sel <= wb_sel_i;
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        wb_regbank_chan #(
            .RST_VAL (RST_VAL)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .wr_en_i  (d0_vld && (d0_dec.kind == REG_CTRL) && (d0_dec.chan == 6'(c))),
            .sel_i    (d0_sel),
            .dat_i    (d0_dat),
            .ctrl_o   (ctrl_o[DATA_W*c +: DATA_W]),
            .wr_stb_o (wr_stb_o[c])
        );
    end

endmodule

// File: tb/tb_wb_repeat_regbank.sv
// tb/tb_wb_repeat_regbank.sv - self-checking bench for wb_repeat_regbank (N_CH=3, RST_VAL=DEAD_0001)
module tb_wb_repeat_regbank;

    localparam int unsigned N_CH = 3;
    localparam logic [31:0] RST  = 32'hDEAD_0001;
`ifdef WB_REGBANK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [4:2]  adr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] dat = '0;
    logic [95:0] stat_bus = '0;
    logic        wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o;
    logic [31:0] wb_dat_o;
    logic [95:0] ctrl_o;
    logic [2:0]  wr_stb_o;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;
    int ack_cnt = 0;
    int stb0_cnt = 0;

    wb_repeat_regbank #(.N_CH(N_CH), .RST_VAL(RST)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_adr_i   (adr),
        .wb_sel_i   (sel),
        .wb_dat_i   (dat),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_rty_o   (wb_rty_o),
        .wb_stall_o (wb_stall_o),
        .wb_dat_o   (wb_dat_o),
        .ctrl_o     (ctrl_o),
        .stat_i     (stat_bus),
        .wr_stb_o   (wr_stb_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-cycle expectations derived from the address map and latencies.
    logic [31:0] m_ctrl [3];
    bit          rd_out, wr_out;
    bit          pw_vld;
    int          pw_w;
    logic [31:0] pw_dat;
    logic [3:0]  pw_sel;
    bit          e_ack, e_err, e_rd;
    logic [31:0] e_dat;
    logic [2:0]  e_stb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) m_ctrl[i] = RST;
            rd_out = 0; wr_out = 0; pw_vld = 0;
            e_ack = 0; e_err = 0; e_rd = 0; e_stb = '0; e_dat = '0;
        end else begin
            int  w;
            bit  en, acc_rd, acc_wr, bad;
            w      = int'(adr);
            en     = cyc && stb;
            acc_rd = en && !we && !rd_out;
            acc_wr = en && we && !wr_out;
            rd_out = acc_rd;
            wr_out = acc_wr;
            e_ack = 0; e_err = 0; e_rd = 0; e_stb = '0;
            if (acc_rd) begin
                e_rd  = 1;
                if (w >= 2 * N_CH) e_dat = 32'h0;
                else if (w % 2 == 1) e_dat = stat_bus[(w / 2) * 32 +: 32];
                else e_dat = m_ctrl[w / 2];
                bad   = ERR_EN && (w >= 2 * N_CH);
                e_ack = !bad;
                e_err = bad;
            end
            if (pw_vld && pw_w < 2 * N_CH && pw_w % 2 == 0) begin
                for (int b = 0; b < 4; b++)
                    if (pw_sel[b]) m_ctrl[pw_w / 2][8*b +: 8] = pw_dat[8*b +: 8];
                e_stb[pw_w / 2] = 1'b1;
            end
            pw_vld = acc_wr; pw_w = w; pw_dat = dat; pw_sel = sel;
            if (acc_wr) begin
                bad   = ERR_EN && !(w < 2 * N_CH && w % 2 == 0);
                e_ack = !bad;
                e_err = bad;
            end
        end
    end

    always @(negedge clk) begin
        if (wb_ack_o) ack_cnt++;
        if (wr_stb_o[0]) stb0_cnt++;
        if (chk_on) begin
            chk("ack", 96'(wb_ack_o), 96'(e_ack));
            chk("err", 96'(wb_err_o), 96'(e_err));
            chk("rty", 96'(wb_rty_o), 96'(0));
            chk("stall", 96'(wb_stall_o), 96'(cyc && stb && !(e_ack || e_err)));
            chk("wr_stb", 96'(wr_stb_o), 96'(e_stb));
            chk("ctrl", ctrl_o, {m_ctrl[2], m_ctrl[1], m_ctrl[0]});
            if (e_rd) chk("rdata", 96'(wb_dat_o), 96'(e_dat));
        end
    end

    task automatic xfer(input bit w, input int word, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output bit ak, output bit er);
        int n;
        cyc = 1; stb = 1; we = w; adr = 3'(word); dat = d; sel = s;
        ak = 0; er = 0; rd = '0; n = 0;
        while (!(ak || er) && n < 20) begin
            @(negedge clk);
            n++;
            ak = wb_ack_o; er = wb_err_o; rd = wb_dat_o;
        end
        chk("xfer_done", 96'(ak || er), 96'(1));
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
    endtask

    initial begin
        logic [31:0] rd;
        bit ak, er;
        chk_on = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_ctrl", ctrl_o, {3{32'hDEAD_0001}});
        chk("rst_stb", 96'(wr_stb_o), 96'(0));
        chk("rst_ack", 96'(wb_ack_o), 96'(0));

        xfer(0, 0, 0, 4'h0, rd, ak, er);
        chk("rd0_rst", 96'(rd), 96'h0DEAD_0001);
        chk("rd0_ack", 96'(ak), 96'(1));

        xfer(1, 4, 32'h0, 4'hF, rd, ak, er);
        xfer(1, 4, 32'h1122_3344, 4'b0101, rd, ak, er);
        chk("wr_sel_ack", 96'(ak), 96'(1));
        chk("wr_sel_ctrl2", 96'(ctrl_o[64 +: 32]), 96'h0022_0044);
        chk("wr_sel_stb", 96'(wr_stb_o), 96'(3'b100));
        xfer(0, 4, 0, 4'h0, rd, ak, er);
        chk("rd4_back", 96'(rd), 96'h0022_0044);

        stat_bus[64 +: 32] = 32'hCAFE_F00D;
        stat_bus[0 +: 32]  = 32'h1234_5678;
        xfer(0, 5, 0, 4'h0, rd, ak, er);
        chk("stat2", 96'(rd), 96'hCAFE_F00D);
        xfer(0, 1, 0, 4'h0, rd, ak, er);
        chk("stat0", 96'(rd), 96'h1234_5678);

        xfer(0, 6, 0, 4'h0, rd, ak, er);
        chk("unmap_ack", 96'(ak), 96'(!ERR_EN));
        chk("unmap_err", 96'(er), 96'(ERR_EN));
        chk("unmap_data", 96'(rd), 96'(0));

        xfer(1, 3, 32'hFFFF_FFFF, 4'hF, rd, ak, er);
        chk("wr_stat_err", 96'(er), 96'(ERR_EN));
        chk("wr_stat_nostb", 96'(wr_stb_o), 96'(0));

        xfer(1, 2, 32'h5555_5555, 4'h0, rd, ak, er);
        chk("sel0_stb", 96'(wr_stb_o), 96'(3'b010));
        chk("sel0_ctrl1", 96'(ctrl_o[32 +: 32]), 96'h0DEAD_0001);

        ack_cnt = 0; stb0_cnt = 0;
        for (int i = 1; i <= 10; i++) xfer(1, 0, 32'(i), 4'hF, rd, ak, er);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_acks", 96'(ack_cnt), 96'(10));
        chk("b2b_stbs", 96'(stb0_cnt), 96'(10));
        chk("b2b_ctrl0", 96'(ctrl_o[31:0]), 96'(10));

        cyc = 1; stb = 1; we = 1; adr = 3'd2; dat = 32'h7777_7777; sel = 4'hF;
        @(posedge clk); #1;
        rst_n = 0; cyc = 0; stb = 0; we = 0;
        @(negedge clk);
        chk("rstmid_ack", 96'(wb_ack_o), 96'(0));
        chk("rstmid_ctrl", ctrl_o, {3{32'hDEAD_0001}});
        repeat (3) begin
            @(negedge clk);
            chk("rstmid_stb", 96'(wr_stb_o), 96'(0));
        end
        @(posedge clk); #1 rst_n = 1;

        cyc = 1; stb = 1; we = 0; adr = 3'd0;
        @(posedge clk); #1;
        cyc = 0; stb = 0;
        @(negedge clk);
        chk("cycdrop_ack", 96'(wb_ack_o), 96'(1));
        chk("cycdrop_dat", 96'(wb_dat_o), 96'h0DEAD_0001);
        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
